// File: rtl/zbb_seqcnt_pkg.sv
// Shared types for the multi-cycle Zbb bit-count engine.
package zbb_seqcnt_pkg;

    typedef enum logic [1:0] {
        CLZ  = 2'b00,
        CTZ  = 2'b01,
        CPOP = 2'b10
    } cntop_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } seqcnt_state_t;

    // The reserved encoding 2'b11 behaves as cpop.
    function automatic cntop_t decode_op(input logic [1:0] op);
        case (op)
            2'b00:   return CLZ;
            2'b01:   return CTZ;
            default: return CPOP;
        endcase
    endfunction

endpackage

// File: rtl/zbb_seqcnt_cnt_chunk.sv
// Combinational per-chunk counter: popcount, trailing zeros (K when empty), nonzero flag.
module cnt_chunk #(
    parameter  int K  = 4,
    localparam int CW = $clog2(K) + 1
) (
    input  logic [K-1:0]  c,
    output logic [CW-1:0] pop,
    output logic [CW-1:0] tz,
    output logic          nz
);

    // Descending scan so the lowest set bit wins the tz assignment.
    always_comb begin
        pop = '0;
        tz  = CW'(K);
        for (int i = K - 1; i >= 0; i--) begin
            pop = pop + CW'(c[i]);
            if (c[i]) tz = CW'(i);
        end
    end

    assign nz = |c;

endmodule

// File: rtl/zbb_seqcnt.sv
// Multi-cycle clz/ctz/cpop engine scanning K bits per cycle behind valid/ready handshakes.
// Build option: define ZBB_SEQCNT_EARLY_EXIT_EN to end clz/ctz at the first nonzero chunk.
module zbb_seqcnt
    import zbb_seqcnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [1:0]       Op,
    input  logic             W64,
    input  logic [WIDTH-1:0] A,
    input  logic             Flush,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] CntResult
);

    localparam int AW     = $clog2(WIDTH) + 1;
    localparam int CW     = $clog2(K) + 1;
    localparam int IW     = $clog2(WIDTH / K);
    localparam int C_FULL = WIDTH / K;
    localparam int C_32   = 32 / K;

    seqcnt_state_t state, state_nxt;

    cntop_t          op_q;
    logic            ew32_q;
    logic [WIDTH-1:0] s_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   res_q;
    logic            found_q;
    logic [IW-1:0]   idx_q;

    logic [CW-1:0]   c_pop, c_tz;
    logic            c_nz;

    cnt_chunk #(.K(K)) u_chunk (
        .c   (s_q[K-1:0]),
        .pop (c_pop),
        .tz  (c_tz),
        .nz  (c_nz)
    );

    // Operand load: clz is computed as ctz of the bit-reversed effective word.
    logic             ew32_in;
    cntop_t           op_in;
    logic [WIDTH-1:0] a_lo, a_rev_lo, a_rev_full, s_load;

    assign ew32_in = (WIDTH == 32) || W64;
    assign op_in   = decode_op(Op);

    always_comb begin
        a_lo       = '0;
        a_rev_lo   = '0;
        a_rev_full = '0;
        a_lo[31:0] = A[31:0];
        for (int i = 0; i < 32; i++)    a_rev_lo[i]   = A[31-i];
        for (int i = 0; i < WIDTH; i++) a_rev_full[i] = A[WIDTH-1-i];
        if (ew32_in) s_load = (op_in == CLZ) ? a_rev_lo : a_lo;
        else         s_load = (op_in == CLZ) ? a_rev_full : A;
    end

    logic [AW-1:0] acc_nxt;
    logic          found_nxt;
    logic [IW-1:0] last_idx;
    logic          early, finish;

    always_comb begin
        acc_nxt   = acc_q;
        found_nxt = found_q;
        if (op_q == CPOP) begin
            acc_nxt = acc_q + AW'(c_pop);
        end else if (!found_q) begin
            acc_nxt   = acc_q + AW'(c_tz);
            found_nxt = c_nz;
        end
    end

    assign last_idx = ew32_q ? IW'(C_32 - 1) : IW'(C_FULL - 1);

`ifdef ZBB_SEQCNT_EARLY_EXIT_EN
    assign early = (op_q != CPOP) && !found_q && c_nz;
`else
    assign early = 1'b0;
`endif

    assign finish = (idx_q == last_idx) || early;

    // Flush also gates ReqReady so a same-cycle request never sees a completed handshake.
    always_comb begin
        state_nxt = state;
        ReqReady  = 1'b0;
        RspValid  = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = !Flush;
                if (ReqValid && !Flush) state_nxt = BUSY;
            end
            BUSY: begin
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                RspValid = 1'b1;
                if (RspReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (Flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= CLZ;
            ew32_q  <= 1'b0;
            s_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
        end else if (Flush) begin
            acc_q   <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
        end else if (state == IDLE && ReqValid) begin
            op_q    <= op_in;
            ew32_q  <= ew32_in;
            s_q     <= s_load;
            acc_q   <= '0;
            found_q <= 1'b0;
            idx_q   <= '0;
        end else if (state == BUSY) begin
            acc_q   <= acc_nxt;
            found_q <= found_nxt;
            s_q     <= s_q >> K;
            idx_q   <= idx_q + IW'(1);
            if (finish) res_q <= acc_nxt;
        end
    end

    assign CntResult = WIDTH'(res_q);

endmodule

// File: tb/tb_zbb_seqcnt.sv
// Scoreboard bench for zbb_seqcnt: one WIDTH=32 and one WIDTH=64 instance, K=4.
module tb_zbb_seqcnt;

`ifdef ZBB_SEQCNT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v32, rdy32, w32, fl32, rv32, rr32;
    logic [1:0]  op32;
    logic [31:0] a32, res32;
    logic        v64, rdy64, w64, fl64, rv64, rr64;
    logic [1:0]  op64;
    logic [63:0] a64, res64;

    zbb_seqcnt #(.WIDTH(32), .K(4)) dut32 (
        .clk(clk), .reset_n(rst_n), .ReqValid(v32), .ReqReady(rdy32), .Op(op32),
        .W64(w32), .A(a32), .Flush(fl32), .RspValid(rv32), .RspReady(rr32), .CntResult(res32)
    );

    zbb_seqcnt #(.WIDTH(64), .K(4)) dut64 (
        .clk(clk), .reset_n(rst_n), .ReqValid(v64), .ReqReady(rdy64), .Op(op64),
        .W64(w64), .A(a64), .Flush(fl64), .RspValid(rv64), .RspReady(rr64), .CntResult(res64)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: response with empty scoreboard at cycle %0d", nm, cyc);
    endtask

    // Monitors: latency on RspValid rise, result on handshake.
    logic pv32 = 1'b0, pv64 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv32 <= 1'b0;
        end else begin
            if (rv32 && !pv32) begin
                if (q32.size() == 0) unexpected("rsp32");
                else chk("lat32", 64'(cyc - q32[0].acc), 64'(q32[0].lat));
            end
            if (rv32 && rr32 && q32.size() > 0) begin
                chk("res32", {32'b0, res32}, q32[0].res);
                void'(q32.pop_front());
            end
            pv32 <= rv32;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv64 <= 1'b0;
        end else begin
            if (rv64 && !pv64) begin
                if (q64.size() == 0) unexpected("rsp64");
                else chk("lat64", 64'(cyc - q64[0].acc), 64'(q64[0].lat));
            end
            if (rv64 && rr64 && q64.size() > 0) begin
                chk("res64", res64, q64[0].res);
                void'(q64.pop_front());
            end
            pv64 <= rv64;
        end
    end

    // Inputs are scrambled right after accept to show they are only sampled then.
    task automatic issue(input int sel, input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] res, input int lat, input bit push);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        if (sel == 32) begin v32 = 1'b1; op32 = op; w32 = w; a32 = a[31:0]; end
        else           begin v64 = 1'b1; op64 = op; w64 = w; a64 = a; end
        forever begin
            @(negedge clk);
            if ((sel == 32) ? rdy32 : rdy64) break;
            n++;
            if (n > 40) begin
                checks++; fails++;
                $display("FAIL accept_timeout%0d: ReqReady never seen", sel);
                v32 = 1'b0; v64 = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        e.res = res; e.lat = lat; e.acc = cyc;
        if (push) begin
            if (sel == 32) q32.push_back(e);
            else           q64.push_back(e);
        end
        v32 = 1'b0; v64 = 1'b0;
        op32 = ~op; a32 = ~a[31:0]; w32 = ~w;
        op64 = ~op; a64 = ~a;       w64 = ~w;
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 32) ? q32.size() : q64.size()) != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++; fails++;
                $display("FAIL drain_timeout%0d: response not seen", sel);
                if (sel == 32) q32.delete(); else q64.delete();
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        v32 = 0; op32 = 0; w32 = 0; a32 = 0; fl32 = 0; rr32 = 1;
        v64 = 0; op64 = 0; w64 = 0; a64 = 0; fl64 = 0; rr64 = 1;

        #12;
        chk("reset_rdy32", 64'(rdy32), 64'd1);
        chk("reset_rv32",  64'(rv32),  64'd0);
        chk("reset_res32", 64'(res32), 64'd0);
        chk("reset_rdy64", 64'(rdy64), 64'd1);
        chk("reset_rv64",  64'(rv64),  64'd0);
        chk("reset_res64", res64,      64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // WIDTH=32 directed vectors
        issue(32, 2'b10, 0, 64'hF0F0_F0F0, 16, 8, 1);              drain(32);
        issue(32, 2'b01, 0, 64'h0000_0100, 8, EE ? 3 : 8, 1);      drain(32);
        issue(32, 2'b00, 0, 64'h0001_0000, 15, EE ? 4 : 8, 1);     drain(32);
        issue(32, 2'b00, 0, 64'h0, 32, 8, 1);                      drain(32);
        issue(32, 2'b01, 1, 64'h0, 32, 8, 1);                      drain(32);
        issue(32, 2'b10, 0, 64'h0, 0, 8, 1);                       drain(32);
        issue(32, 2'b11, 1, 64'h8000_0001, 2, 8, 1);               drain(32);
        issue(32, 2'b00, 1, 64'h8000_0000, 0, EE ? 1 : 8, 1);      drain(32);
        issue(32, 2'b01, 0, 64'h8000_0000, 31, 8, 1);              drain(32);

        // WIDTH=64 directed vectors
        issue(64, 2'b00, 1, 64'hFFFF_FFFF_0000_0001, 31, 8, 1);          drain(64);
        issue(64, 2'b00, 0, 64'hFFFF_FFFF_0000_0001, 0, EE ? 1 : 16, 1); drain(64);
        issue(64, 2'b01, 0, 64'h0000_0100_0000_0000, 40, EE ? 11 : 16, 1); drain(64);
        issue(64, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 16, 1);         drain(64);
        issue(64, 2'b10, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 8, 1);          drain(64);
        issue(64, 2'b00, 0, 64'h0, 64, 16, 1);                           drain(64);
        issue(64, 2'b01, 1, 64'hFFFF_FFFF_0000_0000, 32, 8, 1);          drain(64);
        issue(64, 2'b00, 1, 64'h0000_0000_0000_8000, 16, EE ? 5 : 8, 1); drain(64);

        // Backpressure: result held while RspReady is low
        rr32 = 1'b0;
        issue(32, 2'b01, 0, 64'h0000_0008, 3, EE ? 1 : 8, 1);
        n = 0;
        while (!rv32 && n < 30) begin @(negedge clk); n++; end
        chk("bp_rsp_arrived", 64'(rv32), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rv_hold",  64'(rv32),  64'd1);
            chk("bp_res_hold", 64'(res32), 64'd3);
            chk("bp_rdy_low",  64'(rdy32), 64'd0);
        end
        @(posedge clk); #1 rr32 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rv_drop", 64'(rv32),  64'd0);
        chk("bp_idle",    64'(rdy32), 64'd1);
        issue(32, 2'b10, 0, 64'h0000_0003, 2, 8, 1);               drain(32);

        // Flush in BUSY: no response, back to IDLE
        issue(32, 2'b10, 0, 64'hFFFF_FFFF, 32, 8, 0);
        @(posedge clk); @(posedge clk); #1 fl32 = 1'b1;
        @(posedge clk); #1 fl32 = 1'b0;
        @(negedge clk);
        chk("flush_idle", 64'(rdy32), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rv32) seen = 1'b1;
        end
        chk("flush_no_rsp", 64'(seen), 64'd0);

        // Request together with Flush is dropped
        @(posedge clk); #1 begin v32 = 1'b1; fl32 = 1'b1; op32 = 2'b10; a32 = 32'hFF; end
        @(posedge clk); #1 begin v32 = 1'b0; fl32 = 1'b0; end
        @(negedge clk);
        chk("flush_req_dropped", 64'(rdy32), 64'd1);

        // Asynchronous reset mid-BUSY
        issue(32, 2'b10, 0, 64'hFFFF_FFFF, 32, 8, 0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 64'(rdy32), 64'd1);
        chk("arst_rv",  64'(rv32),  64'd0);
        chk("arst_res", 64'(res32), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(32, 2'b10, 0, 64'hFFFF_FFFF, 32, 8, 1);              drain(32);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
